fir_coef_bank: RTL and testbench

- Double-buffered, runtime-loadable FIR coefficient store with a streaming read engine.
- Successor to the fixed single-table coefficient memory: width, depth and tap count are parametrised, and coefficients load through a write port instead of being hard-coded.
- Host writes a shadow bank while the MAC datapath streams the active bank; a commit swaps the banks only at a burst boundary, so a filter pass never mixes coefficient sets.
- Sits between the control/config interface and the FIR MAC pipeline.

---
 rtl/fir_pkg.sv | 18 +
 rtl/coef_bank_ram.sv | 31 +++
 rtl/fir_coef_bank.sv | 121 ++++++++++++
 tb/tb_fir_coef_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, burst FSM states and tap-count clamping for the FIR coefficient bank
package fir_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 64;
    localparam int DEF_ADR_W = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // A tap count of zero or beyond the bank depth means "use the whole bank"
    function automatic int unsigned clamp_ntaps(input int unsigned n, input int unsigned depth);
        return (n == 0 || n > depth) ? depth : n;
    endfunction

endpackage

// File: rtl/coef_bank_ram.sv
// coef_bank_ram: one DEPTH x WIDTH coefficient bank with a single write port and async read
module coef_bank_ram
    import fir_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADR_W = DEF_ADR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [ADR_W-1:0] rd_adr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Register array: cleared on reset, one word written per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[wr_adr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_adr];

endmodule

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: double-buffered FIR coefficient store with a ready/valid burst read engine
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADR_W = DEF_ADR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_err,
    input  logic             commit,
    input  logic [ADR_W:0]   ntaps_in,
    input  logic             rd_start,
    output logic [WIDTH-1:0] coef_out,
    output logic [ADR_W-1:0] coef_idx,
    output logic             coef_valid,
    output logic             coef_last,
    input  logic             coef_ready,
    output logic             busy,
    output logic             commit_pending,
    output logic             active_bank
);

    localparam int NT_W = ADR_W + 1;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] cnt_q, cnt_d;
    logic [NT_W-1:0]  ntaps_q, ntaps_d;
    logic             active_q, active_d;
    logic             pend_q, pend_d;
    logic             wr_err_q, wr_err_d;
    logic [WIDTH-1:0] coef_out_q, coef_out_d;
    logic [ADR_W-1:0] coef_idx_q, coef_idx_d;
    logic             coef_valid_q, coef_valid_d;
    logic             coef_last_q, coef_last_d;

    logic [WIDTH-1:0] rd0, rd1, rd_word;
    logic             wr_ok, hs, last_hs, swap, load;

    // The shadow bank is the one not being streamed; bank 0 is shadow while bank 1 is active
    coef_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADR_W(ADR_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && active_q),
        .wr_adr  (wr_adr),
        .wr_data (wr_data),
        .rd_adr  (cnt_q),
        .rd_data (rd0)
    );

    coef_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADR_W(ADR_W)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !active_q),
        .wr_adr  (wr_adr),
        .wr_data (wr_data),
        .rd_adr  (cnt_q),
        .rd_data (rd1)
    );

    // Next-state: bank swap only between bursts, output register reloads whenever it is free
    always_comb begin
        hs           = coef_valid_q && coef_ready;
        last_hs      = hs && coef_last_q;
        swap         = pend_q && (state_q == IDLE || last_hs);
        wr_ok        = wr_en && !pend_q;
        load         = state_q == BURST && !(coef_valid_q && coef_last_q) && (!coef_valid_q || coef_ready);
        rd_word      = active_q ? rd1 : rd0;
        active_d     = active_q ^ swap;
        ntaps_d      = swap ? NT_W'(clamp_ntaps(32'(ntaps_in), DEPTH)) : ntaps_q;
        pend_d       = !swap && (pend_q || commit);
        wr_err_d     = wr_en && pend_q;
        state_d      = (state_q == IDLE && rd_start) ? BURST : (last_hs ? IDLE : state_q);
        cnt_d        = (state_q == IDLE) ? '0 : (load ? cnt_q + ADR_W'(1) : cnt_q);
        coef_out_d   = load ? rd_word : coef_out_q;
        coef_idx_d   = load ? cnt_q : coef_idx_q;
        coef_last_d  = load ? ({1'b0, cnt_q} == ntaps_q - NT_W'(1)) : coef_last_q;
        coef_valid_d = load || (coef_valid_q && !hs);
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ntaps_q      <= NT_W'(DEPTH);
            active_q     <= 1'b0;
            pend_q       <= 1'b0;
            wr_err_q     <= 1'b0;
            coef_out_q   <= '0;
            coef_idx_q   <= '0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ntaps_q      <= ntaps_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            wr_err_q     <= wr_err_d;
            coef_out_q   <= coef_out_d;
            coef_idx_q   <= coef_idx_d;
            coef_valid_q <= coef_valid_d;
            coef_last_q  <= coef_last_d;
        end
    end

    assign wr_err         = wr_err_q;
    assign coef_out       = coef_out_q;
    assign coef_idx       = coef_idx_q;
    assign coef_valid     = coef_valid_q;
    assign coef_last      = coef_last_q;
    assign busy           = state_q == BURST;
    assign commit_pending = pend_q;
    assign active_bank    = active_q;

endmodule

// File: tb/tb_fir_coef_bank.sv
// tb_fir_coef_bank: table-driven and directed checks of fir_coef_bank against a bank/array model
module tb_fir_coef_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_adr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_err;
    logic        commit = 1'b0;
    logic [6:0]  ntaps_in = 7'd64;
    logic        rd_start = 1'b0;
    logic [15:0] coef_out;
    logic [5:0]  coef_idx;
    logic        coef_valid;
    logic        coef_last;
    logic        coef_ready = 1'b1;
    logic        busy;
    logic        commit_pending;
    logic        active_bank;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_bank [2][64];
    logic        m_act;
    int          m_ntaps;
    int          m_nt_next;
    logic        m_pend;

    typedef struct {
        logic [6:0] n_in;
        int         taps;
        int         stall_idx;
        int         stall_cyc;
    } vec_t;

    vec_t tbl [7];

    fir_coef_bank dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_adr         (wr_adr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .commit         (commit),
        .ntaps_in       (ntaps_in),
        .rd_start       (rd_start),
        .coef_out       (coef_out),
        .coef_idx       (coef_idx),
        .coef_valid     (coef_valid),
        .coef_last      (coef_last),
        .coef_ready     (coef_ready),
        .busy           (busy),
        .commit_pending (commit_pending),
        .active_bank    (active_bank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++)
                m_bank[b][i] = 16'h0000;
        m_act     = 1'b0;
        m_ntaps   = 64;
        m_nt_next = 64;
        m_pend    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " valid"}, 32'(coef_valid), 32'd0);
        chk({tag, " out"}, 32'(coef_out), 32'd0);
        chk({tag, " idx"}, 32'(coef_idx), 32'd0);
        chk({tag, " last"}, 32'(coef_last), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " pending"}, 32'(commit_pending), 32'd0);
        chk({tag, " bank"}, 32'(active_bank), 32'd0);
        chk({tag, " wr_err"}, 32'(wr_err), 32'd0);
    endtask

    task automatic do_write(input logic [5:0] adr, input logic [15:0] data);
        logic exp_err;
        exp_err = m_pend;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_adr = adr; wr_data = data;
        if (!m_pend) m_bank[~m_act][adr] = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk($sformatf("wr_err adr %0d", adr), 32'(wr_err), 32'(exp_err));
    endtask

    task automatic do_commit(input logic [6:0] n, input int exp_taps);
        @(posedge clk); #1;
        ntaps_in  = n;
        m_nt_next = exp_taps;
        commit    = 1'b1;
        m_pend    = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
        chk("pending after commit", 32'(commit_pending), 32'd1);
    endtask

    task automatic run_burst(input int stall_idx, input int stall_cyc, input string tag);
        logic [15:0] exp_w [$];
        int n, got, cyc, stalled;
        if (m_pend) begin
            m_act   = ~m_act;
            m_ntaps = m_nt_next;
            m_pend  = 1'b0;
        end
        n = m_ntaps;
        for (int i = 0; i < n; i++) exp_w.push_back(m_bank[m_act][i]);
        @(posedge clk); #1;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " bank"}, 32'(active_bank), 32'(m_act));
        got = 0; cyc = 0; stalled = 0;
        while (got < n && cyc < n + stall_cyc + 20) begin
            @(negedge clk);
            cyc++;
            if (coef_valid) begin
                if (coef_idx == 6'(stall_idx) && stalled < stall_cyc) begin
                    coef_ready = 1'b0;
                    stalled++;
                    chk($sformatf("%s hold%0d", tag, stalled), {9'd0, coef_idx, coef_last, coef_out},
                        {9'd0, 6'(got), logic'(got == n - 1), exp_w[got]});
                end else begin
                    coef_ready = 1'b1;
                    chk($sformatf("%s w%0d", tag, got), {9'd0, coef_idx, coef_last, coef_out},
                        {9'd0, 6'(got), logic'(got == n - 1), exp_w[got]});
                    got++;
                end
            end
        end
        coef_ready = 1'b1;
        if (got < n) chk({tag, " burst timeout words"}, 32'(got), 32'(n));
        if (m_pend) begin
            m_act   = ~m_act;
            m_ntaps = m_nt_next;
            m_pend  = 1'b0;
        end
        @(negedge clk);
        chk({tag, " end valid"}, 32'(coef_valid), 32'd0);
        chk({tag, " end busy"}, 32'(busy), 32'd0);
        chk({tag, " end pending"}, 32'(commit_pending), 32'(m_pend));
        chk({tag, " end bank"}, 32'(active_bank), 32'(m_act));
    endtask

    initial begin
        tbl[0] = '{7'd4,   4,  2, 3};
        tbl[1] = '{7'd0,   64, -1, 0};
        tbl[2] = '{7'd65,  64, 10, 1};
        tbl[3] = '{7'd1,   1,  0, 2};
        tbl[4] = '{7'd64,  64, 63, 2};
        tbl[5] = '{7'd17,  17, -1, 0};
        tbl[6] = '{7'd127, 64, 5, 4};
        model_reset();

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_burst(-1, 0, "zeros");

        do_write(6'd0, 16'h0079);
        do_write(6'd1, 16'h0060);
        do_write(6'd2, 16'hFFCA);
        do_write(6'd3, 16'hFECA);
        do_commit(7'd4, 4);
        run_burst(-1, 0, "four");
        chk("four bank1", 32'(active_bank), 32'd1);

        for (int i = 0; i < 4; i++) do_write(6'(i), 16'($urandom));
        fork
            run_burst(-1, 0, "commit_mid");
            begin
                repeat (2) @(posedge clk);
                #1;
                ntaps_in  = 7'd4;
                m_nt_next = 4;
                commit    = 1'b1;
                m_pend    = 1'b1;
                @(posedge clk); #1;
                commit = 1'b0;
                chk("mid pending", 32'(commit_pending), 32'd1);
                chk("mid old bank", 32'(active_bank), 32'd1);
                do_write(6'd0, 16'hDEAD);
            end
        join
        run_burst(-1, 0, "after_swap");

        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < 8; k++)
                do_write(6'($urandom_range(0, tbl[t].taps - 1)), 16'($urandom));
            do_commit(tbl[t].n_in, tbl[t].taps);
            run_burst(tbl[t].stall_idx, tbl[t].stall_cyc, $sformatf("vec%0d", t));
        end

        @(posedge clk); #1;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_burst(-1, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
